data_mem_responder: RTL and testbench

- Memory-side responder for the multicycle RISC-V CPU's load/store port. The CPU is the initiator: it issues one word request per transaction over a valid/ready request channel.
- This block services each request from an internal word RAM after a programmable number of wait states. It returns the result over a valid/ready response channel.
- It replaces the zero-latency data memory so the CPU FSM can be exercised with realistic stalls.
- Only one transaction is outstanding at any time.

---
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-RAM responder for the CPU load/store port: one outstanding request,
// serviced after LATENCY cycles and returned over a valid/ready response channel.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        commit;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;

  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_err;
  logic [AW-1:0] c_idx;

  logic [31:0] mem [DEPTH];

  // With LATENCY=1 the commit happens on the accept edge, so the live
  // request fields are used instead of the captured ones.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    c_we      = we_q;
    c_addr    = addr_q;
    c_wdata   = wdata_q;
    c_wstrb   = wstrb_q;
    case (state)
      IDLE: begin
        c_we    = req_we;
        c_addr  = req_addr;
        c_wdata = req_wdata;
        c_wstrb = req_wstrb;
        if (req_valid) begin
          if (LATENCY == 1) begin
            commit    = 1'b1;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH));
  assign c_idx = c_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= (state_nxt == IDLE);
      resp_valid <= (state_nxt == RESP);
      if (commit) begin
        resp_rdata <= (!c_err && !c_we) ? mem[c_idx] : 32'd0;
        resp_err   <= c_err;
      end else if (state == RESP && resp_ready) begin
        resp_rdata <= 32'd0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Request fields are data only; they need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  // A reset on the commit edge suppresses the store.
  always_ff @(posedge clk) begin
    if (rst && commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_wstrb[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 2, 4 and 1
// sharing clock and reset, each driven through its own signal slot.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [31:0] resp_rdata [3];
  logic [3:0]  req_wstrb [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] model [64];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH  (64),
      .LATENCY(g == 0 ? 2 : (g == 1 ? 4 : 1))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wstrb (req_wstrb[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for its response, optionally hold resp_ready low
  // for 'hold' cycles (checking stability), then complete the handshake.
  task automatic do_req(input int i, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_wstrb[i] = wstrb;
    req_valid[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 50) begin edge1(); n++; end
    if (!req_ready[i]) check("accept_timeout", 32'(req_ready[i]), 32'd1);
    edge1();
    req_valid[i] = 1'b0;
    lat = 1;
    while (!resp_valid[i] && lat < 40) begin edge1(); lat++; end
    if (!resp_valid[i]) check("resp_timeout", 32'(resp_valid[i]), 32'd1);
    rdata = resp_rdata[i];
    err   = resp_err[i];
    for (int k = 0; k < hold; k++) begin
      edge1();
      check("hold_valid", 32'(resp_valid[i]), 32'd1);
      check("hold_rdata", resp_rdata[i], rdata);
      check("hold_err", 32'(resp_err[i]), 32'(err));
    end
    resp_ready[i] = 1'b1;
    edge1();
    resp_ready[i] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, a0, a1, n;
    logic        seen;

    rst = 1'b0;
    req_valid = '0; req_we = '0; resp_ready = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_wstrb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd1);
      check("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
      check("rst_resp_rdata", resp_rdata[i], 32'd0);
      check("rst_resp_err", 32'(resp_err[i]), 32'd0);
    end

    // LATENCY=2 instance: fill the whole RAM with known values
    for (int w = 0; w < 64; w++) begin
      model[w] = 32'h1000_0000 + w * 32'h0001_0101;
      do_req(0, 1'b1, 32'(w * 4), model[w], 4'hF, 0, rd, er, lat);
    end

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    model[4] = 32'hDEADBEEF;
    check("st_lat", 32'(lat), 32'd2);
    check("st_err", 32'(er), 32'd0);
    check("st_rdata", rd, 32'd0);
    check("st_req_ready", 32'(req_ready[0]), 32'd1);

    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld_lat", 32'(lat), 32'd2);
    check("ld_rdata", rd, 32'hDEADBEEF);
    check("ld_err", 32'(er), 32'd0);

    do_req(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd, er, lat);
    model[4] = 32'hDE22BE44;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("strb_rdata", rd, 32'hDE22BE44);

    do_req(0, 1'b1, 32'h14, 32'h99999999, 4'b0000, 0, rd, er, lat);
    check("strb0_err", 32'(er), 32'd0);

    do_req(0, 1'b0, 32'h12, 32'h0, 4'h0, 5, rd, er, lat);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_req_ready", 32'(req_ready[0]), 32'd1);
    check("mis_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("mis_resp_err_clr", 32'(resp_err[0]), 32'd0);

    do_req(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);

    for (int w = 0; w < 64; w++) begin
      do_req(0, 1'b0, 32'(w * 4), 32'h0, 4'h0, 0, rd, er, lat);
      check($sformatf("readback_%0d", w), rd, model[w]);
    end

    // LATENCY=4 instance: reset during WAIT abandons the store
    do_req(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 0, rd, er, lat);
    check("l4_lat", 32'(lat), 32'd4);
    req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'hCAFEF00D; req_wstrb[1] = 4'hF;
    req_valid[1] = 1'b1;
    edge1();
    req_valid[1] = 1'b0;
    edge1();
    rst = 1'b0;
    edge1();
    rst = 1'b1;
    seen = resp_valid[1];
    for (int k = 0; k < 10; k++) begin
      edge1();
      seen = seen | resp_valid[1];
    end
    check("midrst_no_resp", 32'(seen), 32'd0);
    check("midrst_req_ready", 32'(req_ready[1]), 32'd1);
    do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    check("midrst_old_data", rd, 32'h12345678);

    // LATENCY=1 instance: back-to-back loads with resp_ready tied high
    do_req(2, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd, er, lat);
    check("l1_lat", 32'(lat), 32'd1);
    do_req(2, 1'b1, 32'h4, 32'h600DCAFE, 4'hF, 0, rd, er, lat);
    resp_ready[2] = 1'b1;
    req_we[2] = 1'b0; req_addr[2] = 32'h0; req_valid[2] = 1'b1;
    @(posedge clk);
    a0 = cyc;
    #1;
    req_addr[2] = 32'h4;
    check("b2b_valid0", 32'(resp_valid[2]), 32'd1);
    check("b2b_rdata0", resp_rdata[2], 32'h0BADF00D);
    n = 0;
    while (!req_ready[2] && n < 10) begin edge1(); n++; end
    @(posedge clk);
    a1 = cyc;
    #1;
    req_valid[2] = 1'b0;
    check("b2b_valid1", 32'(resp_valid[2]), 32'd1);
    check("b2b_rdata1", resp_rdata[2], 32'h600DCAFE);
    check("b2b_spacing", 32'(a1 - a0), 32'd2);
    edge1();
    resp_ready[2] = 1'b0;
    check("b2b_done", 32'(resp_valid[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
